// File: rtl/arb_pkg.sv
// Shared types, default sizing and helpers for the round-robin decode arbiter.
package arb_pkg;

  // Controller states: no grant outstanding, or a grant being held.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Default sizing: 16 requesters, 4-bit index, 8-cycle hold timeout.
  localparam int N_DEF        = 16;
  localparam int IW_DEF       = 4;
  localparam int HOLD_MAX_DEF = 8;

  // Widest supported requester count; helpers are sized for it and sliced by users.
  localparam int N_MAX  = 16;
  localparam int IW_MAX = 4;

  // Binary index to one-hot select line, sized for the widest configuration.
  function automatic logic [N_MAX-1:0] idx_to_onehot(input logic [IW_MAX-1:0] idx);
    logic [N_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_pick.sv
// Combinational rotating-priority search: the first candidate at or after
// start_idx (ascending, wrapping) wins; one index can optionally be excluded.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] start_idx,
  input  logic          excl_en,
  input  logic [IW-1:0] excl_idx,
  output logic          found,
  output logic [IW-1:0] winner
);

  logic [N-1:0]  excl_mask;
  logic [N-1:0]  cand;
  logic [N-1:0]  rotated;
  logic [IW-1:0] offset;

  // Build the exclusion mask (only the pre-empted owner is ever excluded).
  always_comb begin
    excl_mask = '0;
    if (excl_en) begin
      excl_mask[excl_idx] = 1'b1;
    end
  end

  assign cand = eligible & ~excl_mask;

  // Rotate candidates so start_idx lands at bit 0; N is a power of two so
  // the IW-bit addition wraps modulo N for free.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < N; k++) begin
      rotated[k] = cand[IW'(start_idx + IW'(k))];
    end
  end

  // Lowest set bit of the rotated vector is the nearest candidate.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = IW'(k);
      end
    end
  end

  // Rotate the winning offset back into an absolute requester index.
  assign winner = start_idx + offset;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a one-hot select decoder bank. The owner keeps
// the grant while it stays eligible, subject to an optional hold timeout that
// hands the resource to a waiting competitor.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IW       = IW_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid,
  output logic          preempt
);

  // Hold counter only needs to reach HOLD_MAX (or 1 when the timeout is off).
  localparam int            CW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT  = (HOLD_MAX == 0) ? CW'(1) : CW'(HOLD_MAX);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  arb_state_e    state;
  arb_state_e    state_n;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] last_n;
  logic [IW-1:0] idx_n;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] cnt_n;
  logic          valid_n;
  logic          preempt_n;

  logic [N-1:0]     eligible;
  logic [N_MAX-1:0] owner_oh;
  logic [N_MAX-1:0] grant_oh_n;
  logic             owner_elig;
  logic             others;
  logic             timeout_hit;
  logic             excl_en;
  logic [IW-1:0]    start_idx;
  logic             found;
  logic [IW-1:0]    winner;

  assign eligible = req & mask;

  // While holding, last_idx is the current owner.
  assign owner_oh    = idx_to_onehot(IW_MAX'(last_idx));
  assign owner_elig  = eligible[last_idx];
  assign others      = |(eligible & ~owner_oh[N-1:0]);
  assign timeout_hit = (HOLD_MAX != 0) && (hold_cnt == CNT_SAT);

  // Exclude the owner only when the timeout is what forces the new search.
  assign excl_en   = (state == HOLD) && owner_elig && timeout_hit && others;
  assign start_idx = last_idx + IW'(1);

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .eligible  (eligible),
    .start_idx (start_idx),
    .excl_en   (excl_en),
    .excl_idx  (last_idx),
    .found     (found),
    .winner    (winner)
  );

  // Next-state and next-output decision for the grant controller.
  always_comb begin
    state_n   = state;
    last_n    = last_idx;
    idx_n     = grant_idx;
    cnt_n     = hold_cnt;
    valid_n   = grant_valid;
    preempt_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable && found) begin
          state_n = HOLD;
          last_n  = winner;
          idx_n   = winner;
          cnt_n   = CW'(1);
          valid_n = 1'b1;
        end
      end

      HOLD: begin
        if (!enable) begin
          // Drop the grant but remember the owner for rotation on resume.
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (!owner_elig) begin
          // Owner released or was masked off: hand over back-to-back if possible.
          if (found) begin
            last_n  = winner;
            idx_n   = winner;
            cnt_n   = CW'(1);
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end else if (excl_en) begin
          // Owner overstayed while someone else waits: force the hand-over.
          last_n    = winner;
          idx_n     = winner;
          cnt_n     = CW'(1);
          preempt_n = 1'b1;
        end else if (hold_cnt < CNT_SAT) begin
          // Saturating count so a late competitor triggers the timeout at once.
          cnt_n = hold_cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  assign grant_oh_n = idx_to_onehot(IW_MAX'(idx_n));

  // Controller state and registered outputs; grant is decoded from the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_idx    <= LAST_RST;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_n;
      last_idx    <= last_n;
      hold_cnt    <= cnt_n;
      grant       <= valid_n ? grant_oh_n[N-1:0] : '0;
      grant_idx   <= idx_n;
      grant_valid <= valid_n;
      preempt     <= preempt_n;
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter (N=16, HOLD_MAX=8): a table of
// directed vectors, hand-written timeout/rotation sequences, and random
// traffic compared against a behavioural model.
module tb_rr_decode_arbiter;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int HM = 8;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          preempt;

  int total = 0;
  int bad   = 0;

  rr_decode_arbiter #(.N(N), .IW(IW), .HOLD_MAX(HM)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .mask        (mask),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit m_valid;
  bit m_pre;
  int m_idx;
  int m_last;
  int m_cnt;

  // Nearest eligible requester after 'after', ascending with wrap, skipping 'excl'.
  function automatic int search(input logic [N-1:0] elig, input int after, input int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (after + k) % N;
      if (elig[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [N-1:0] elig;
    int w;
    elig  = req & mask;
    m_pre = 0;
    if (rst) begin
      m_valid = 0; m_idx = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_valid) begin
      w = search(elig, m_last, -1);
      if (enable && w >= 0) begin
        m_valid = 1; m_idx = w; m_last = w; m_cnt = 1;
      end
    end else if (!enable) begin
      m_valid = 0;
    end else if (!elig[m_idx]) begin
      w = search(elig, m_idx, -1);
      if (w >= 0) begin m_idx = w; m_last = w; m_cnt = 1; end
      else m_valid = 0;
    end else if (m_cnt == HM && search(elig, m_idx, m_idx) >= 0) begin
      w = search(elig, m_idx, m_idx);
      m_idx = w; m_last = w; m_cnt = 1; m_pre = 1;
    end else if (m_cnt < HM) begin
      m_cnt++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update model from the current inputs, then sample after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [N-1:0] exp_grant;
    exp_grant = m_valid ? (N'(1) << m_idx) : '0;
    chk({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    chk({tag, ".idx"},   32'(grant_idx), 32'(m_idx));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_valid));
    chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic [N-1:0] e_grant;
    logic [IW-1:0] e_idx;
    logic         e_valid;
    logic         e_pre;
  } vec_t;

  vec_t tv[19];

  initial begin
    int pre_cnt;
    rst = 1'b1; enable = 1'b1; req = '0; mask = '1;
    m_valid = 0; m_pre = 0; m_idx = 0; m_last = N - 1; m_cnt = 0;

    // rst en req mask -> grant idx valid preempt
    tv[0]  = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 16'h0004, 16'hFFFF, 16'h0004, 4'd2,  1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 16'h0004, 16'hFFFF, 16'h0004, 4'd2,  1'b1, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 16'h0004, 16'hFFFF, 16'h0004, 4'd2,  1'b1, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 16'h0011, 16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 16'h0011, 16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0000, 4'd4,  1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 16'h0011, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 16'h0011, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b1, 16'h0011, 16'hFFFF, 16'h0010, 4'd4,  1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'd4,  1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b1, 16'h4000, 16'hFFFF, 16'h4000, 4'd14, 1'b1, 1'b0};
    tv[13] = '{1'b0, 1'b1, 16'h8001, 16'hFFFF, 16'h8000, 4'd15, 1'b1, 1'b0};
    tv[14] = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b1, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1'b1, 1'b0};
    tv[16] = '{1'b0, 1'b1, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1'b1, 1'b0};
    tv[17] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tv[18] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 4'd0,  1'b1, 1'b0};

    #1;
    for (int i = 0; i < 19; i++) begin
      rst = tv[i].rst; enable = tv[i].en; req = tv[i].req; mask = tv[i].mask;
      step();
      chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(tv[i].e_grant));
      chk($sformatf("vec%0d.idx", i),   32'(grant_idx), 32'(tv[i].e_idx));
      chk($sformatf("vec%0d.valid", i), 32'(grant_valid), 32'(tv[i].e_valid));
      chk($sformatf("vec%0d.pre", i),   32'(preempt), 32'(tv[i].e_pre));
    end

    // Rotation fairness: every owner drops its bit right after being granted.
    rst = 1'b1; req = '0; mask = '1; enable = 1'b1;
    step(); step();
    rst = 1'b0; req = '1;
    step();
    chk("rot.first", 32'(grant_idx), 32'd0);
    for (int i = 0; i < N; i++) begin
      req = ~(N'(1) << grant_idx);
      step();
      chk($sformatf("rot%0d.idx", i), 32'(grant_idx), 32'((i + 1) % N));
      chk($sformatf("rot%0d.valid", i), 32'(grant_valid), 32'd1);
      chk_model($sformatf("rot%0d", i));
    end

    // Timeout pre-emption: 3 holds, 9 joins in grant cycle 2, switch after 8 cycles.
    rst = 1'b1; req = '0;
    step(); step();
    rst = 1'b0; req = 16'h0008;
    pre_cnt = 0;
    step();
    chk("to.c1", 32'(grant), 32'h0008);
    step();
    chk("to.c2", 32'(grant), 32'h0008);
    req = 16'h0208;
    for (int i = 3; i <= 8; i++) begin
      step();
      if (preempt) pre_cnt++;
      chk($sformatf("to.c%0d", i), 32'(grant), 32'h0008);
    end
    step();
    if (preempt) pre_cnt++;
    chk("to.switch", 32'(grant), 32'h0200);
    chk("to.pulse", 32'(preempt), 32'd1);
    req = 16'h0200;
    for (int i = 0; i < 12; i++) begin
      step();
      if (preempt) pre_cnt++;
      chk($sformatf("to.alone%0d", i), 32'(grant), 32'h0200);
    end
    chk("to.pulse_count", 32'(pre_cnt), 32'd1);

    // Random traffic against the model; occasional reset, enable and mask changes.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom) & N'($urandom);
      mask   = ($urandom_range(0, 15) == 0) ? N'($urandom) : '1;
      step();
      chk_model($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d.onehot", i), 32'($countones(grant) <= 1), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
